data_sram_responder: RTL and testbench

- Slave end of the CPU data-SRAM interface: en / we[3:0] / addr / wdata in, rdata out one cycle later.
- Contains a local RAM region and a small memory-mapped config-register window (LED, scratch, timer, timer interrupt).
- The timer interrupt drives the CPU's 8-bit hardware-interrupt input.
- Sits beside the CPU top in the SoC wrapper and replaces the bare data SRAM in the bench.

---
 rtl/data_sram_responder_pkg.sv | 16 +
 rtl/data_sram_responder_confreg_timer.sv | 40 ++++
 rtl/data_sram_responder.sv | 63 ++++++
 tb/tb_data_sram_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: config-window offsets, ID value and byte-lane merge shared by the responder.
package data_sram_responder_pkg;
  localparam logic [7:0] CONF_LED = 8'h00;
  localparam logic [7:0] CONF_SCRATCH = 8'h04;
  localparam logic [7:0] CONF_TIMER = 8'h08;
  localparam logic [7:0] CONF_CMP = 8'h0c;
  localparam logic [7:0] CONF_INTC = 8'h10;
  localparam logic [7:0] CONF_ID = 8'h14;
  localparam logic [31:0] CONF_ID_VALUE = 32'h4c41_3031;
  localparam int HWINT_TIMER = 0;
  function automatic logic [31:0] byte_merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] we);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = we[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/data_sram_responder_confreg_timer.sv
// data_sram_responder_confreg_timer: free-running timer, compare register and latched timer interrupt.
module data_sram_responder_confreg_timer
  import data_sram_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr,
  input  logic [3:0]  i_we,
  input  logic [7:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [7:0]  o_hw_int
);
  logic [31:0] r_timer, r_cmp;
  logic r_en, r_pend;
  logic w_match, w_clr;
  assign w_match = r_en && r_timer == r_cmp;
  assign w_clr = i_wr && i_off == CONF_INTC && i_we[0] && i_wdata[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
      r_cmp <= '1;
      r_en <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_timer <= (i_wr && i_off == CONF_TIMER) ? byte_merge(r_timer, i_wdata, i_we) : r_timer + 32'd1;
      if (i_wr && i_off == CONF_CMP) r_cmp <= byte_merge(r_cmp, i_wdata, i_we);
      if (i_wr && i_off == CONF_INTC && i_we[0]) r_en <= i_wdata[0];
      // a new match outranks a simultaneous write-1-to-clear
      r_pend <= w_match || (r_pend && !w_clr);
    end
  end
  always_comb begin
    o_rdata = i_off == CONF_TIMER ? r_timer :
              i_off == CONF_CMP   ? r_cmp :
              i_off == CONF_INTC  ? {30'd0, r_pend, r_en} : 32'd0;
    o_hw_int = '0;
    o_hw_int[HWINT_TIMER] = r_pend;
  end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-SRAM slave with local RAM and a memory-mapped config/timer window.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int RAM_AW = 14,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
  parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [7:0]  hw_int
);
  logic [31:0] r_mem [2**RAM_AW];
  logic [31:0] r_rdata, r_scratch;
  logic [15:0] r_led;
  logic w_hit, w_wr;
  logic [7:0] w_off;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0] w_tmr_rdata, w_conf_rdata;
  assign w_hit = (data_sram_addr & CONF_MASK) == CONF_BASE;
  assign w_wr = data_sram_en && w_hit && |data_sram_we;
  assign w_off = {data_sram_addr[7:2], 2'b00};
  assign w_idx = data_sram_addr[RAM_AW+1:2];
  assign w_conf_rdata = w_off == CONF_LED     ? {16'd0, r_led} :
                        w_off == CONF_SCRATCH ? r_scratch :
                        w_off == CONF_ID      ? CONF_ID_VALUE : w_tmr_rdata;
  data_sram_responder_confreg_timer u_tmr (
    .clk      (clk),
    .reset    (reset),
    .i_wr     (w_wr),
    .i_we     (data_sram_we),
    .i_off    (w_off),
    .i_wdata  (data_sram_wdata),
    .o_rdata  (w_tmr_rdata),
    .o_hw_int (hw_int)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_led <= '0;
      r_scratch <= '0;
    end else if (data_sram_en) begin
      r_rdata <= w_hit ? w_conf_rdata : r_mem[w_idx];
      if (w_wr && w_off == CONF_LED) begin
        r_led[7:0] <= data_sram_we[0] ? data_sram_wdata[7:0] : r_led[7:0];
        r_led[15:8] <= data_sram_we[1] ? data_sram_wdata[15:8] : r_led[15:8];
      end
      if (w_wr && w_off == CONF_SCRATCH) r_scratch <= byte_merge(r_scratch, data_sram_wdata, data_sram_we);
    end
  end
  // RAM array is left unreset; reset only blocks the write
  always_ff @(posedge clk)
    if (!reset && data_sram_en && !w_hit && |data_sram_we)
      r_mem[w_idx] <= byte_merge(r_mem[w_idx], data_sram_wdata, data_sram_we);
  assign data_sram_rdata = r_rdata;
  assign led = r_led;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed plus randomized checks against a behavioural model of the responder.
module tb_data_sram_responder;
  localparam logic [31:0] CB = 32'hbfaf_0000;
  logic clk = 1'b0;
  logic reset, en;
  logic [3:0] we;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] led;
  logic [7:0] hw_int;
  int checks = 0, errors = 0;
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata, m_scr, m_tmr, m_cmp;
  logic [15:0] m_led;
  logic m_en, m_pend;
  logic [7:0] offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10, 8'h14, 8'h18, 8'h40};
  always #5 clk = ~clk;
  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .hw_int          (hw_int)
  );
  function automatic logic [31:0] mrg(logic [31:0] o, logic [31:0] n, logic [3:0] w);
    logic [31:0] m;
    m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    return (o & ~m) | (n & m);
  endfunction
  function automatic logic [31:0] conf_rd(logic [7:0] off);
    case (off)
      8'h00: return {16'h0, m_led};
      8'h04: return m_scr;
      8'h08: return m_tmr;
      8'h0c: return m_cmp;
      8'h10: return {30'h0, m_pend, m_en};
      8'h14: return 32'h4c41_3031;
      default: return 32'h0;
    endcase
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(logic r, logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    logic hit, np, ne, match;
    logic [7:0] off;
    int idx;
    logic [31:0] nt, t;
    reset = r; en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    hit = (a & 32'hffff_0000) == CB;
    off = {a[7:2], 2'b00};
    idx = int'(a[15:2]);
    if (r) begin
      m_rdata = 0; m_led = 0; m_scr = 0; m_tmr = 0; m_cmp = '1; m_en = 0; m_pend = 0;
    end else begin
      match = m_en && m_tmr == m_cmp;
      nt = m_tmr + 1;
      np = m_pend;
      ne = m_en;
      if (e) begin
        m_rdata = hit ? conf_rd(off) : m_mem[idx];
        if (w != 0) begin
          if (!hit) m_mem[idx] = mrg(m_mem[idx], d, w);
          else case (off)
            8'h00: begin t = mrg({16'h0, m_led}, d, w); m_led = t[15:0]; end
            8'h04: m_scr = mrg(m_scr, d, w);
            8'h08: nt = mrg(m_tmr, d, w);
            8'h0c: m_cmp = mrg(m_cmp, d, w);
            8'h10: if (w[0]) begin ne = d[0]; if (d[1]) np = 0; end
            default: ;
          endcase
        end
      end
      if (match) np = 1;
      m_tmr = nt; m_pend = np; m_en = ne;
    end
    #1;
    chk("rdata", rdata, m_rdata);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("hw_int", {24'h0, hw_int}, {31'h0, m_pend});
  endtask
  task automatic idle();
    cyc(0, 0, 4'h0, 32'h0, 32'h0);
  endtask
  initial begin
    cyc(1, 0, 4'h0, 32'h0, 32'h0);
    cyc(1, 0, 4'h0, 32'h0, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_hw_int", {24'h0, hw_int}, 32'h0);
    cyc(0, 1, 4'hf, 32'h100, 32'h1234_5678);
    cyc(0, 1, 4'h0, 32'h100, 32'h0);
    chk("ram_full_wr", rdata, 32'h1234_5678);
    cyc(0, 1, 4'h2, 32'h100, 32'h0000_ab00);
    cyc(0, 1, 4'h0, 32'h100, 32'h0);
    chk("ram_lane_wr", rdata, 32'h1234_ab78);
    cyc(0, 1, 4'hf, 32'h100, 32'h1111_1111);
    cyc(0, 1, 4'hf, 32'h100, 32'h2222_2222);
    chk("read_first", rdata, 32'h1111_1111);
    cyc(0, 1, 4'h0, 32'h100, 32'h0);
    chk("read_after_wr", rdata, 32'h2222_2222);
    cyc(0, 1, 4'h0, 32'h0001_0100, 32'h0);
    chk("alias", rdata, 32'h2222_2222);
    idle();
    chk("hold_rdata", rdata, 32'h2222_2222);
    cyc(0, 1, 4'hf, CB, 32'hffff_a5a5);
    chk("led_out", {16'h0, led}, 32'h0000_a5a5);
    cyc(0, 1, 4'h0, CB, 32'h0);
    chk("led_rd", rdata, 32'h0000_a5a5);
    cyc(0, 1, 4'h0, CB + 32'h14, 32'h0);
    chk("id_rd", rdata, 32'h4c41_3031);
    cyc(0, 1, 4'h0, CB + 32'h40, 32'h0);
    chk("unmapped_rd", rdata, 32'h0);
    cyc(0, 1, 4'hf, CB + 32'h08, 32'h10);
    cyc(0, 1, 4'hf, CB + 32'h0c, 32'h20);
    cyc(0, 1, 4'hf, CB + 32'h10, 32'h1);
    for (int i = 0; i < 64 && !hw_int[0]; i++) idle();
    chk("irq_rise", {31'h0, hw_int[0]}, 32'h1);
    cyc(0, 1, 4'h0, CB + 32'h08, 32'h0);
    chk("irq_timer", rdata, 32'h21);
    cyc(0, 1, 4'hf, CB + 32'h10, 32'h3);
    cyc(0, 1, 4'h0, CB + 32'h10, 32'h0);
    chk("w1c", rdata, 32'h1);
    cyc(0, 1, 4'hf, CB + 32'h08, 32'hffff_fffe);
    cyc(0, 1, 4'hf, CB + 32'h0c, 32'h0);
    idle();
    idle();
    chk("wrap_irq", {24'h0, hw_int}, 32'h1);
    cyc(0, 1, 4'hf, CB + 32'h10, 32'h3);
    chk("wrap_clr", {24'h0, hw_int}, 32'h0);
    cyc(0, 1, 4'hf, CB + 32'h08, 32'h100);
    cyc(0, 1, 4'hf, CB + 32'h0c, 32'h102);
    idle();
    cyc(0, 1, 4'hf, CB + 32'h10, 32'h3);
    chk("w1c_vs_set", {24'h0, hw_int}, 32'h1);
    cyc(0, 1, 4'hf, CB + 32'h10, 32'h3);
    chk("w1c_later", {24'h0, hw_int}, 32'h0);
    cyc(0, 1, 4'hf, CB + 32'h08, 32'h5555);
    cyc(0, 1, 4'h0, CB + 32'h08, 32'h0);
    chk("tmr_wr_holds", rdata, 32'h5555);
    cyc(0, 1, 4'hf, CB + 32'h04, 32'hcafe_f00d);
    cyc(1, 1, 4'hf, 32'h100, 32'hdead_beef);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_led", {16'h0, led}, 32'h0);
    cyc(0, 1, 4'h0, 32'h100, 32'h0);
    chk("rst_mid_ram", rdata, 32'h2222_2222);
    cyc(0, 1, 4'h0, CB + 32'h04, 32'h0);
    chk("rst_scratch", rdata, 32'h0);
    cyc(0, 1, 4'h0, CB + 32'h0c, 32'h0);
    chk("rst_cmp", rdata, 32'hffff_ffff);
    for (int k = 0; k < 8; k++) cyc(0, 1, 4'hf, 32'h200 + 32'(k * 4), $urandom);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) < 5)
        a = (32'($urandom_range(0, 3)) << 16) | 32'h200 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      else
        a = CB | {24'h0, offs[$urandom_range(0, 7)]} | 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
